uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
- 8N1 UART receiver with a small receive FIFO. It consumes the SoC's `rxd` pin and feeds the CPU IO read mux.
- It is the receive-side counterpart of the UART transmit emitter and runs on the same clock and baud parameters.
- The IO decode pops one byte per CPU read of the RX data register. Status (valid, count, errors) is exposed for the UART control register.

Parameters:
- clk_freq_hz, 27_000_000, system clock frequency in Hz.
- baud_rate, 115200, line rate; CLKS_PER_BIT = clk_freq_hz / baud_rate (integer divide; 234 at defaults).
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_rx  in  1  asynchronous serial input; idle high.
- o_data  out  8  FIFO head byte; 0 when o_valid=0.
- o_valid  out  1  FIFO non-empty.
- i_ready  in  1  pop strobe; pop occurs when o_valid && i_ready.
- o_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- o_frame_err  out  1  sticky: a stop bit was sampled low.
- o_overrun  out  1  sticky: a byte arrived while the FIFO was full.
- i_clr_err  in  1  clears both sticky flags.

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - Synchroniser flops go to 1 and the FSM goes to IDLE.
  - Bit counter and clock counter go to 0; FIFO pointers go to 0.
  - Outputs: o_valid=0, o_data=0, o_count=0, o_frame_err=0, o_overrun=0.
  - FIFO storage is not reset.
- Reset mid-frame aborts the frame; no partial byte is ever pushed.
- i_rx passes through a 2-flop synchroniser (rx_s). All FSM decisions use rx_s.
- FSM states: IDLE, START, DATA, STOP. Clock counter `cnt` counts 0..CLKS_PER_BIT-1.
  - IDLE: rx_s==0 → START with cnt=0.
  - START: when cnt reaches CLKS_PER_BIT/2 - 1, sample rx_s.
    - If 1 (glitch): → IDLE, nothing pushed.
    - If 0: → DATA with cnt=0, bit index 0.
  - DATA: when cnt reaches CLKS_PER_BIT-1, sample rx_s into the shift register (LSB first) and set cnt=0. After the 8th sample → STOP.
  - STOP: when cnt reaches CLKS_PER_BIT-1, sample rx_s, then → IDLE.
    - Sample 1: push the byte.
    - Sample 0: set o_frame_err and discard the byte.
- Sampling is therefore at bit centres. A new start bit is accepted from the cycle after the STOP sample.
- Latency: a pushed byte is visible (o_valid=1, o_data=byte, o_count incremented) on the cycle after the STOP sample edge.
- FIFO: show-ahead; o_data = head entry while non-empty. Pointers wrap modulo DEPTH; the count distinguishes full from empty.
  - Pop when empty: ignored; no pointer or count change.
  - Push when full with no simultaneous pop: byte dropped, o_overrun set, FIFO contents unchanged.
  - Push and pop in the same cycle (any occupancy, including full): both take effect, o_count unchanged, no overrun.
- Sticky flags: i_clr_err clears them on the next edge. If a set event and i_clr_err occur in the same cycle, set wins.
- A frame error never affects the FIFO.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each START/DATA/STOP sample is the 2-of-3 majority of rx_s at cnt = centre-1, centre and centre+1. The decision still occurs at the centre+1 cycle; all later timing shifts by 1 cycle (visible latency +1).
- Undefined: a single sample of rx_s at the centre, exactly as above.

Test Plan:
- Defaults; send 0x55 then 0xA3 at 234 clks/bit with 1 stop bit → o_valid rises; pops return 0x55 then 0xA3; o_count goes 2→1→0; no error flags.
- 100-clock low pulse on idle i_rx (shorter than half-bit 117) → FSM returns to IDLE; o_valid stays 0, o_count 0.
- Frame 0x3C with the stop bit held low → o_frame_err=1, o_count=0; then i_clr_err for 1 cycle → o_frame_err=0.
- DEPTH=4; send 0x01..0x05 with no pops → o_count=4, o_overrun=1, pops return 0x01..0x04 only.
- FIFO full with i_ready held high on the push cycle of byte 0x77 → o_count stays 4, o_overrun=0, 0x77 is the last byte popped.
- Assert i_rst during bit 4 of frame 0xF0, release, then send 0x12 → only 0x12 is received; all outputs are 0 during reset.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a small show-ahead receive FIFO with sticky error flags.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority vote around each bit centre.
module uart_rx_fifo #(
    parameter int clk_freq_hz = 27_000_000,
    parameter int baud_rate   = 115200,
    parameter int DEPTH       = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_rx,
    output logic [7:0]               o_data,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_frame_err,
    output logic                     o_overrun,
    input  logic                     i_clr_err
);

    localparam int CLKS_PER_BIT = clk_freq_hz / baud_rate;
    localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int AW           = $clog2(DEPTH);

    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [CW-1:0] CNT_START = CW'(CLKS_PER_BIT / 2);
`else
    localparam logic [CW-1:0] CNT_START = CW'(CLKS_PER_BIT / 2 - 1);
`endif
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic          rx_meta_q, rx_s_q;
    logic          sample;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q;
    logic          shift_en, push, ferr_set;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q;
    logic          pop, full, wr, ovr_set;
    logic          frame_err_q, overrun_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= i_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // Two previous synchronised samples; the decision cycle supplies the third.
    logic rx_h1_q, rx_h2_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_h1_q <= 1'b1;
            rx_h2_q <= 1'b1;
        end else begin
            rx_h1_q <= rx_s_q;
            rx_h2_q <= rx_h1_q;
        end
    end

    assign sample = (rx_s_q & rx_h1_q) | (rx_s_q & rx_h2_q) | (rx_h1_q & rx_h2_q);
`else
    assign sample = rx_s_q;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_en = 1'b0;
        push     = 1'b0;
        ferr_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == CNT_START) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = sample ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    shift_en = 1'b1;
                    cnt_d    = '0;
                    bit_d    = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d    = '0;
                    state_d  = IDLE;
                    push     = sample;
                    ferr_set = !sample;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // LSB arrives first, so shift in from the top.
    always_ff @(posedge i_clk) begin
        if (shift_en) begin
            shift_q <= {sample, shift_q[7:1]};
        end
    end

    assign pop     = (count_q != '0) && i_ready;
    assign full    = (count_q == FULL_CNT);
    assign wr      = push && (!full || pop);
    assign ovr_set = push && full && !pop;

    always_ff @(posedge i_clk) begin
        if (wr) begin
            mem_q[wptr_q] <= shift_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (wr) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({wr, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // A set event in the same cycle as a clear keeps the flag set.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (ferr_set) begin
                frame_err_q <= 1'b1;
            end else if (i_clr_err) begin
                frame_err_q <= 1'b0;
            end
            if (ovr_set) begin
                overrun_q <= 1'b1;
            end else if (i_clr_err) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign o_valid     = (count_q != '0);
    assign o_data      = o_valid ? mem_q[rptr_q] : 8'h00;
    assign o_count     = count_q;
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;

endmodule
